// File: rtl/multi_dataflow_job_scheduler.sv
// Round-robin job scheduler in front of the multi_dataflow HWPE control FSM.
// Arbitrates NUM_REQ job descriptors, flags reconfiguration on config change,
// starts the accelerator, waits for done (optional timeout) and reports completion.
module multi_dataflow_job_scheduler #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CFG_W   = 8,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TMO_W   = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  output logic [NUM_REQ-1:0]         req_ready_o,
  input  logic [NUM_REQ*CFG_W-1:0]   req_cfg_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_in_addr_i,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_out_addr_i,
  input  logic [TMO_W-1:0]           tmo_limit_i,
  output logic                       job_start_o,
  output logic [CFG_W-1:0]           job_cfg_o,
  output logic [ADDR_W-1:0]          job_in_addr_o,
  output logic [ADDR_W-1:0]          job_out_addr_o,
  input  logic                       job_done_i,
  output logic                       reconfig_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       busy_o,
  output logic [NUM_REQ-1:0]         done_o,
  output logic                       err_o,
  output logic                       tmo_sticky_o
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [2:0] {StIdle, StReconf, StStart, StRun, StFinish} state_e;

  state_e              state_q, state_d;
  logic [IdW-1:0]      rr_ptr_q, rr_ptr_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic [CFG_W-1:0]    last_cfg_q, last_cfg_d;
  logic [CFG_W-1:0]    job_cfg_q, job_cfg_d;
  logic [ADDR_W-1:0]   job_in_q, job_in_d;
  logic [ADDR_W-1:0]   job_out_q, job_out_d;
  logic [IdW-1:0]      grant_q, grant_d;
  logic [TMO_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                sticky_q, sticky_d;

  logic                grant_found;
  logic [IdW-1:0]      grant_idx;
  int unsigned         cand;
  logic [CFG_W-1:0]    sel_cfg;
  logic [ADDR_W-1:0]   sel_in, sel_out;

  // Cyclic search for the first valid requester at or after rr_ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && req_valid_i[IdW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IdW'(cand);
      end
    end
  end

  assign sel_cfg = req_cfg_i[grant_idx*CFG_W +: CFG_W];
  assign sel_in  = req_in_addr_i[grant_idx*ADDR_W +: ADDR_W];
  assign sel_out = req_out_addr_i[grant_idx*ADDR_W +: ADDR_W];

  // Next-state, datapath updates and state-decoded pulse outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cfg_valid_d = cfg_valid_q;
    last_cfg_d  = last_cfg_q;
    job_cfg_d   = job_cfg_q;
    job_in_d    = job_in_q;
    job_out_d   = job_out_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    sticky_d    = sticky_q;
    req_ready_o = '0;
    job_start_o = 1'b0;
    reconfig_o  = 1'b0;
    done_o      = '0;
    err_o       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_found && !clear_i) begin
          req_ready_o[grant_idx] = 1'b1;
          job_cfg_d = sel_cfg;
          job_in_d  = sel_in;
          job_out_d = sel_out;
          grant_d   = grant_idx;
          rr_ptr_d  = (grant_idx == IdW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d   = (!cfg_valid_q || sel_cfg != last_cfg_q) ? StReconf : StStart;
        end
      end
      StReconf: begin
        reconfig_o  = 1'b1;
        last_cfg_d  = job_cfg_q;
        cfg_valid_d = 1'b1;
        state_d     = StStart;
      end
      StStart: begin
        job_start_o = 1'b1;
        cnt_d       = '0;
        state_d     = StRun;
      end
      StRun: begin
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        // Done has priority over a timeout hitting in the same cycle.
        if (job_done_i) begin
          err_d   = 1'b0;
          state_d = StFinish;
        end else if (tmo_limit_i != '0 && cnt_q == tmo_limit_i - 1'b1) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          state_d  = StFinish;
        end
      end
      StFinish: begin
        done_o[grant_q] = 1'b1;
        err_o           = err_q;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Soft clear abandons any job in flight and forgets the loaded config.
    if (clear_i) begin
      state_d     = StIdle;
      rr_ptr_d    = '0;
      cfg_valid_d = 1'b0;
      last_cfg_d  = '0;
      job_cfg_d   = '0;
      job_in_d    = '0;
      job_out_d   = '0;
      grant_d     = '0;
      cnt_d       = '0;
      err_d       = 1'b0;
      sticky_d    = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Datapath registers: arbitration pointer, config tracking, job descriptor, timeout.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q    <= '0;
      cfg_valid_q <= 1'b0;
      last_cfg_q  <= '0;
      job_cfg_q   <= '0;
      job_in_q    <= '0;
      job_out_q   <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cfg_valid_q <= cfg_valid_d;
      last_cfg_q  <= last_cfg_d;
      job_cfg_q   <= job_cfg_d;
      job_in_q    <= job_in_d;
      job_out_q   <= job_out_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      sticky_q    <= sticky_d;
    end
  end

  assign job_cfg_o      = job_cfg_q;
  assign job_in_addr_o  = job_in_q;
  assign job_out_addr_o = job_out_q;
  assign grant_id_o     = grant_q;
  assign busy_o         = (state_q != StIdle);
  assign tmo_sticky_o   = sticky_q;

endmodule

// File: tb/tb_multi_dataflow_job_scheduler.sv
// Self-checking bench for multi_dataflow_job_scheduler: directed job scenarios with
// literal expectations plus a timestamp-based reference model compared every cycle.
module tb_multi_dataflow_job_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [31:0]  req_cfg = '0;
  logic [127:0] req_in = '0;
  logic [127:0] req_out = '0;
  logic [15:0]  tmo = '0;
  logic         job_start;
  logic [7:0]   job_cfg;
  logic [31:0]  job_in, job_out;
  logic         job_done = 1'b0;
  logic         reconfig;
  logic [1:0]   grant_id;
  logic         busy;
  logic [3:0]   done;
  logic         err;
  logic         sticky;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  multi_dataflow_job_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .clear_i       (clear),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .req_cfg_i     (req_cfg),
    .req_in_addr_i (req_in),
    .req_out_addr_i(req_out),
    .tmo_limit_i   (tmo),
    .job_start_o   (job_start),
    .job_cfg_o     (job_cfg),
    .job_in_addr_o (job_in),
    .job_out_addr_o(job_out),
    .job_done_i    (job_done),
    .reconfig_o    (reconfig),
    .grant_id_o    (grant_id),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .tmo_sticky_o  (sticky)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (job timeline by cycle stamps) ----------------
  localparam int Never = 1 << 30;
  int          cyc;
  bit          m_active, m_reconf, m_err, m_cfgv, m_sticky;
  int          m_acc, m_st, m_fin, m_grant, m_rr;
  logic [7:0]  m_cfg, m_last;
  logic [31:0] m_in, m_out;

  task automatic model_reset();
    m_active = 0; m_reconf = 0; m_err = 0; m_cfgv = 0; m_sticky = 0;
    m_acc = 0; m_st = Never; m_fin = Never; m_grant = 0; m_rr = 0;
    m_cfg = '0; m_last = '0; m_in = '0; m_out = '0;
  endtask

  // Check every cycle at the falling edge, then advance the model over the next rising edge.
  always @(negedge clk) begin
    bit         idle;
    int         g, k;
    logic [3:0] e_ready, e_done;
    if (!rst_n) begin
      model_reset();
      cyc = 0;
    end else begin
      idle = !m_active || cyc > m_fin;
      g = -1;
      for (int i = 0; i < 4; i++)
        if (g < 0 && req_valid[(m_rr + i) % 4]) g = (m_rr + i) % 4;
      e_ready = (idle && !clear && g >= 0) ? 4'(1 << g) : 4'b0;
      e_done  = (!idle && cyc == m_fin) ? 4'(1 << m_grant) : 4'b0;
      chk("m_ready", req_ready, e_ready);
      chk("m_busy", busy, !idle);
      chk("m_reconfig", reconfig, !idle && m_reconf && cyc == m_acc + 1);
      chk("m_start", job_start, !idle && cyc == m_st);
      chk("m_done", done, e_done);
      chk("m_err", err, !idle && cyc == m_fin && m_err);
      chk("m_sticky", sticky, m_sticky);
      chk("m_grant_id", grant_id, m_grant);
      chk("m_job_cfg", job_cfg, m_cfg);
      chk("m_job_in", job_in, m_in);
      chk("m_job_out", job_out, m_out);
      if (clear) begin
        model_reset();
      end else if (idle && g >= 0) begin
        m_active = 1; m_acc = cyc; m_grant = g; m_fin = Never;
        m_cfg = req_cfg[g*8 +: 8]; m_in = req_in[g*32 +: 32]; m_out = req_out[g*32 +: 32];
        m_reconf = !m_cfgv || (m_cfg != m_last);
        m_st = cyc + (m_reconf ? 2 : 1);
        m_cfgv = 1; m_last = m_cfg;
        m_rr = (g + 1) % 4;
      end else if (!idle && cyc > m_st && m_fin == Never) begin
        k = cyc - m_st - 1;  // cycles spent running so far
        if (job_done) begin
          m_fin = cyc + 1; m_err = 0;
        end else if (tmo != 0 && k == int'(tmo) - 1) begin
          m_fin = cyc + 1; m_err = 1; m_sticky = 1;
        end
      end
      cyc++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Submit one job from requester r; done is raised on RUN cycle index run_idx.
  task automatic do_job(input int r, input logic [7:0] cfg, input bit exp_reconf,
                        input int run_idx);
    req_valid[r] = 1'b1;
    req_cfg[r*8 +: 8] = cfg;
    #1 chk("job_ready", req_ready, 4'(1 << r));
    tick();
    req_valid[r] = 1'b0;
    #1 chk("job_reconfig", reconfig, exp_reconf);
    if (exp_reconf) begin
      tick();
      #1;
    end
    chk("job_start", job_start, 1'b1);
    tick();
    repeat (run_idx) tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    #1 chk("job_done", done, 4'(1 << r));
    chk("job_err", err, 1'b0);
    tick();
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    for (int k = 0; k < 4; k++) begin
      req_in[k*32 +: 32]  = 32'h1000_0000 + 32'(k) * 32'h100;
      req_out[k*32 +: 32] = 32'h2000_0000 + 32'(k) * 32'h100;
    end
    // Reset state
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 4'b0);
    chk("rst_start", job_start, 1'b0);
    chk("rst_reconfig", reconfig, 1'b0);
    chk("rst_sticky", sticky, 1'b0);
    chk("rst_cfg", job_cfg, 8'h0);
    chk("rst_grant", grant_id, 2'd0);
    chk("rst_ready", req_ready, 4'b0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single job: accept c0, reconfig c1, start c2, done_i c10, done_o c11
    req_valid[0] = 1'b1;
    req_cfg[7:0] = 8'd3;
    #1 chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid[0] = 1'b0;
    #1 chk("t1_reconfig", reconfig, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_cfg", job_cfg, 8'd3);
    chk("t1_in", job_in, 32'h1000_0000);
    chk("t1_out", job_out, 32'h2000_0000);
    tick();
    #1 chk("t1_start", job_start, 1'b1);
    repeat (8) tick();
    job_done = 1'b1;
    tick();
    job_done = 1'b0;
    #1 chk("t1_done", done, 4'b0001);
    chk("t1_err", err, 1'b0);
    tick();
    #1 chk("t1_idle", busy, 1'b0);

    // Same-cfg back-to-back: no reconfig, start one cycle after accept
    do_job(0, 8'd3, 1'b0, 2);
    do_job(1, 8'd3, 1'b0, 2);

    // Round-robin with all requesters valid
    do_clear();
    req_cfg = {8'd3, 8'd3, 8'd3, 8'd3};
    req_valid = 4'hF;
    #1;
    for (int j = 0; j < 5; j++) begin
      for (int k = 0; k < 16; k++) begin
        if (req_ready != 4'b0) break;
        tick();
        #1;
      end
      chk("rr_grant", req_ready, rr_exp[j]);
      for (int k = 0; k < 8; k++) begin
        tick();
        if (j == 4) req_valid = 4'h0;
        #1;
        if (job_start) break;
      end
      chk("rr_start", job_start, 1'b1);
      tick();
      tick();
      job_done = 1'b1;
      tick();
      job_done = 1'b0;
      tick();
      #1;
    end

    // Timeout: limit 5, done withheld; rr now points at requester 1
    tmo = 16'd5;
    req_valid[1] = 1'b1;
    #1 chk("tmo_ready", req_ready, 4'b0010);
    tick();
    req_valid[1] = 1'b0;
    #1 chk("tmo_start", job_start, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      #1 chk("tmo_run_no_done", done, 4'b0);
    end
    tick();
    #1 chk("tmo_done", done, 4'b0010);
    chk("tmo_err", err, 1'b1);
    chk("tmo_sticky", sticky, 1'b1);
    tick();
    tick();
    #1 chk("tmo_sticky_held", sticky, 1'b1);
    do_clear();
    #1 chk("tmo_sticky_cleared", sticky, 1'b0);

    // Done and timeout in the same cycle: done wins
    do_job(0, 8'd3, 1'b1, 4);
    #1 chk("coll_sticky", sticky, 1'b0);

    // Clear mid-RUN abandons the job and forces a reconfig on the next one
    tmo = 16'd0;
    req_valid[1] = 1'b1;
    req_cfg[15:8] = 8'd5;
    tick();
    req_valid[1] = 1'b0;
    repeat (3) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    #1 chk("clr_busy", busy, 1'b0);
    chk("clr_done", done, 4'b0);
    job_done = 1'b1;  // outside RUN: ignored
    tick();
    job_done = 1'b0;
    tick();
    do_job(0, 8'd5, 1'b1, 1);

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
